seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//   Time-multiplexed scanner for a DIGITS-wide 7-segment display bank. Sits directly upstream of
//   bcd7seg: accepts a packed hex word through a valid/ready handshake, double-buffers it, and
//   emits one nibble per scan slot on hex (into bcd7seg) plus an active-low one-hot digit select.
//   New words are committed only at frame boundaries, so no frame ever mixes old and new digits.
// PARAMETERS
//   DIGITS     8       number of digits scanned, >=2
//   DIV        1000    clocks per digit slot, >=1
//   RESET_VAL  0       power-up display word, 4*DIGITS bits
// PORTS
//   clk        in   1          clock; all state changes on rising edge
//   rst_n      in   1          asynchronous, active-low reset
//   in_valid   in   1          in_data/in_blank valid
//   in_ready   out  1          block can accept a word this cycle
//   in_data    in   4*DIGITS   packed nibbles; digit k = in_data[4k+3:4k], digit 0 rightmost
//   in_blank   in   DIGITS     per-digit blank mask, 1 = digit dark
//   hex        out  4          nibble for current slot, to bcd7seg
//   dig_sel    out  DIGITS     active-low one-hot digit enable; all 1 = dark
//   frame_start out 1          1-cycle pulse when slot 0 begins
// BEHAVIOUR
//   - Reset (async assert, sync release): prescaler=0, idx=0, shadow data=RESET_VAL, shadow blank=0,
//     pending empty, in_ready=1, hex=RESET_VAL[3:0], dig_sel=~1 (digit 0 on), frame_start=0.
//     Reset mid-frame discards any pending word.
//   - Prescaler counts 0..DIV-1, wraps; tick = (count==DIV-1). DIV=1 -> tick every cycle.
//   - idx advances on tick, DIGITS-1 wraps to 0. Frame boundary = tick && idx==DIGITS-1.
//   - Handshake: transfer when in_valid && in_ready; word+mask captured into pending register,
//     pending_full set, in_ready=0 from next cycle. in_ready = !pending_full (registered).
//     in_data must be held by source while in_valid && !in_ready.
//   - Commit: at a frame boundary with pending_full, pending -> shadow, pending_full cleared;
//     in_ready=1 the cycle after. Capture in the same cycle as a boundary (pending empty) lands in
//     pending and commits at the NEXT boundary; never straight to shadow.
//   - Outputs registered, updated on the same edge as idx: at the edge where idx becomes k,
//     hex=shadow nibble k and dig_sel=~(1<<k), using shadow as committed on that same edge
//     (slot 0 after commit shows new word). Blanked digit: dig_sel=all 1, hex=4'h0.
//   - frame_start=1 exactly on the cycle after the edge idx wraps to 0, else 0.
//   - Latency word->display: from handshake, visible at start of the first full frame following.
//   - No arithmetic beyond counters; counter widths $clog2(DIV), $clog2(DIGITS), min 1 bit.
// CONFIGURATION
//   SEG_LZB_EN defined: leading-zero blanking. At commit (and reset), digits from DIGITS-1 downward
//     whose nibble is 0 are marked blank until the first nonzero nibble; digit 0 never auto-blanked.
//     Effective blank = in_blank | lzb mask.
//   SEG_LZB_EN undefined: only in_blank controls blanking; all zeros displayed.
// TESTING
//   - Reset: rst_n=0 mid-run -> immediately dig_sel=~1, hex=RESET_VAL[3:0], in_ready=1, no pending.
//   - Scan, DIGITS=4 DIV=3, word 0x1234: dig_sel 1110,1101,1011,0111 each 3 cycles with hex
//     4,3,2,1; frame_start pulses every 12 cycles.
//   - Mid-frame load 0xABCD at slot 1: in_ready->0, hex keeps old word until wrap, then slot 0
//     hex=D; in_ready=1 one cycle after commit.
//   - Backpressure: second word 0x5555 held valid while pending full -> accepted only after
//     commit, displayed next frame; no word lost or duplicated.
//   - in_blank=4'b0010 -> slot 1 dig_sel=1111 hex=0; other slots normal.
//   - SEG_LZB_EN, word 0x0050: digits 3,2 dark, digit 1=5, digit 0=0 shown; without macro
//     all four lit.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scanner with a valid/ready input and frame-aligned double buffering.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_ctrl #(
   parameter int                    DIGITS    = 8,
   parameter int                    DIV       = 1000,
   parameter logic [4*DIGITS-1:0]   RESET_VAL = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   in_data,
   input  logic [DIGITS-1:0]     in_blank,
   output logic [3:0]            hex,
   output logic [DIGITS-1:0]     dig_sel,
   output logic                  frame_start
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // Marks zero digits from the top down until the first nonzero one; digit 0 stays lit.
   function automatic logic [DIGITS-1:0] f_lzb(input logic [4*DIGITS-1:0] d);
      logic lead;
      f_lzb = '0;
      lead  = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         lead     = lead && (d[4*k +: 4] == 4'h0);
         f_lzb[k] = lead;
      end
   endfunction

`ifdef SEG_LZB_EN
   localparam logic [DIGITS-1:0] RESET_BLANK = f_lzb(RESET_VAL);
`else
   localparam logic [DIGITS-1:0] RESET_BLANK = '0;
`endif

   logic [PW-1:0]          r_presc;
   logic [IW-1:0]          r_idx;
   logic [4*DIGITS-1:0]    r_pend_data;
   logic [DIGITS-1:0]      r_pend_blank;
   logic                   r_pend_full;
   logic [4*DIGITS-1:0]    r_shadow_data;
   logic [DIGITS-1:0]      r_shadow_blank;
   logic [3:0]             r_hex;
   logic [DIGITS-1:0]      r_dig_sel;
   logic                   r_frame_start;

   logic                   w_tick;
   logic                   w_last;
   logic                   w_boundary;
   logic                   w_commit;
   logic                   w_accept;
   logic [IW-1:0]          w_idx_next;
   logic [4*DIGITS-1:0]    w_shadow_data_next;
   logic [DIGITS-1:0]      w_shadow_blank_next;
   logic [DIGITS-1:0]      w_commit_blank;
   logic [3:0]             w_nib [DIGITS];
   logic [DIGITS-1:0]      w_onehot;
   logic [3:0]             w_sel_hex;
   logic                   w_sel_blank;

   assign w_tick     = (r_presc == PW'(DIV - 1));
   assign w_last     = (r_idx == IW'(DIGITS - 1));
   assign w_boundary = w_tick && w_last;
   assign w_commit   = w_boundary && r_pend_full;
   assign w_accept   = in_valid && !r_pend_full;
   assign w_idx_next = w_last ? '0 : r_idx + IW'(1);

`ifdef SEG_LZB_EN
   assign w_commit_blank = r_pend_blank | f_lzb(r_pend_data);
`else
   assign w_commit_blank = r_pend_blank;
`endif

   // The slot being entered must see a word committed on the same edge.
   assign w_shadow_data_next  = w_commit ? r_pend_data    : r_shadow_data;
   assign w_shadow_blank_next = w_commit ? w_commit_blank : r_shadow_blank;

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign w_nib[gi]    = w_shadow_data_next[4*gi +: 4];
         assign w_onehot[gi] = (w_idx_next == IW'(gi));
      end
   endgenerate

   assign w_sel_hex   = w_nib[w_idx_next];
   assign w_sel_blank = w_shadow_blank_next[w_idx_next];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc        <= '0;
         r_idx          <= '0;
         r_pend_data    <= '0;
         r_pend_blank   <= '0;
         r_pend_full    <= 1'b0;
         r_shadow_data  <= RESET_VAL;
         r_shadow_blank <= RESET_BLANK;
         r_hex          <= RESET_VAL[3:0];
         r_dig_sel      <= ~DIGITS'(1);
         r_frame_start  <= 1'b0;
      end else begin
         r_frame_start <= w_boundary;
         r_presc       <= w_tick ? '0 : r_presc + PW'(1);

         if (w_accept) begin
            r_pend_data  <= in_data;
            r_pend_blank <= in_blank;
            r_pend_full  <= 1'b1;
         end else if (w_commit) begin
            r_pend_full  <= 1'b0;
         end

         if (w_tick) begin
            r_idx          <= w_idx_next;
            r_shadow_data  <= w_shadow_data_next;
            r_shadow_blank <= w_shadow_blank_next;
            r_hex          <= w_sel_blank ? 4'h0 : w_sel_hex;
            r_dig_sel      <= w_sel_blank ? '1 : ~w_onehot;
         end
      end
   end

   assign in_ready    = !r_pend_full;
   assign hex         = r_hex;
   assign dig_sel     = r_dig_sel;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (DIGITS=4, DIV=3): table of words with hand-computed frames,
// plus hand sequences for backpressure and mid-frame reset. Honours SEG_LZB_EN if defined.
module tb_seg_scan_ctrl;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [3:0]  in_blank;
   logic [3:0]  hex;
   logic [3:0]  dig_sel;
   logic        frame_start;

   seg_scan_ctrl #(
      .DIGITS    (4),
      .DIV       (3),
      .RESET_VAL (16'h8421)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_blank    (in_blank),
      .hex         (hex),
      .dig_sel     (dig_sel),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] word;
      logic [3:0]  blank;
      int          off;
      logic [15:0] exp_dig;   // {slot3, slot2, slot1, slot0} dig_sel
      logic [15:0] exp_hex;   // {slot3, slot2, slot1, slot0} hex
   } vec_t;

   vec_t        vecs [7];
   int          n_cmp = 0;
   int          n_err = 0;
   int          pos   = 0;
   logic [15:0] prev_dig;
   logic [15:0] prev_hex;

   task automatic step();
      @(posedge clk);
      #1;
      pos = (pos + 1) % 12;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @pos %0d: got %h, expected %h", name, pos, act, exp);
      end
   endtask

   task automatic chk_disp(input string tag, input logic [15:0] d16, input logic [15:0] h16);
      int slot;
      slot = pos / 3;
      chk({tag, " dig_sel"}, {12'h0, dig_sel}, {12'h0, d16[4*slot +: 4]});
      chk({tag, " hex"},     {12'h0, hex},     {12'h0, h16[4*slot +: 4]});
   endtask

   task automatic check_frame(input string tag, input logic [15:0] d16, input logic [15:0] h16,
                              input int start, input bit fs0);
      for (int c = start; c < 12; c++) begin
         chk_disp(tag, d16, h16);
         chk({tag, " frame_start"}, {15'h0, frame_start}, {15'h0, (c == 0) && fs0});
         if (c == 0) chk({tag, " in_ready"}, {15'h0, in_ready}, 16'h1);
         step();
      end
   endtask

   task automatic load(input logic [15:0] word, input logic [3:0] blank);
      bit ok;
      bit hs;
      ok       = 1'b0;
      in_data  = word;
      in_blank = blank;
      in_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         hs = in_ready;
         step();
         chk_disp("hold-old", prev_dig, prev_hex);
         if (hs) begin
            ok = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
      if (!ok) begin
         n_cmp++;
         n_err++;
         $display("FAIL handshake timeout: got in_ready=0, expected 1 within 40 cycles");
      end else begin
         chk("in_ready after capture", {15'h0, in_ready}, 16'h0);
      end
   endtask

   task automatic wait_frame();
      do begin
         step();
         if (pos != 0) chk_disp("hold-old", prev_dig, prev_hex);
      end while (pos != 0);
   endtask

   initial begin
      vecs[0] = '{16'h1234, 4'b0000, 0,  16'h7BDE, 16'h1234};
      vecs[1] = '{16'hABCD, 4'b0000, 4,  16'h7BDE, 16'hABCD};
      vecs[2] = '{16'h5555, 4'b0000, 11, 16'h7BDE, 16'h5555};
      vecs[3] = '{16'h1234, 4'b0010, 2,  16'h7BFE, 16'h1204};
`ifdef SEG_LZB_EN
      vecs[4] = '{16'h0050, 4'b0000, 7,  16'hFFDE, 16'h0050};
      vecs[5] = '{16'h0000, 4'b0000, 5,  16'hFFFE, 16'h0000};
`else
      vecs[4] = '{16'h0050, 4'b0000, 7,  16'h7BDE, 16'h0050};
      vecs[5] = '{16'h0000, 4'b0000, 5,  16'h7BDE, 16'h0000};
`endif
      vecs[6] = '{16'h9000, 4'b1001, 9,  16'hFBDF, 16'h0000};

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_blank = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset dig_sel",     {12'h0, dig_sel},     16'h000E);
      chk("reset hex",         {12'h0, hex},         16'h0001);
      chk("reset in_ready",    {15'h0, in_ready},    16'h1);
      chk("reset frame_start", {15'h0, frame_start}, 16'h0);
      rst_n    = 1'b1;
      pos      = 0;
      prev_dig = 16'h7BDE;
      prev_hex = 16'h8421;

      foreach (vecs[v]) begin
         for (int i = 0; i < vecs[v].off; i++) begin
            step();
            chk_disp("hold-old", prev_dig, prev_hex);
         end
         load(vecs[v].word, vecs[v].blank);
         wait_frame();
         check_frame($sformatf("vec%0d", v), vecs[v].exp_dig, vecs[v].exp_hex, 0, 1'b1);
         $display("vec%0d word=%h blank=%b off=%0d checked (errors so far %0d)",
                  v, vecs[v].word, vecs[v].blank, vecs[v].off, n_err);
         prev_dig = vecs[v].exp_dig;
         prev_hex = vecs[v].exp_hex;
      end

      // Backpressure: second word held valid while the first is still pending.
      load(16'h1234, 4'b0000);
      in_data  = 16'h5555;
      in_blank = 4'b0000;
      in_valid = 1'b1;
      do begin
         step();
         if (pos != 0) begin
            chk_disp("bp-old", prev_dig, prev_hex);
            chk("bp in_ready held low", {15'h0, in_ready}, 16'h0);
         end
      end while (pos != 0);
      chk_disp("bp-first", 16'h7BDE, 16'h1234);
      chk("bp frame_start", {15'h0, frame_start}, 16'h1);
      chk("bp in_ready after commit", {15'h0, in_ready}, 16'h1);
      step();
      in_valid = 1'b0;
      chk("bp in_ready after second capture", {15'h0, in_ready}, 16'h0);
      check_frame("bp-first", 16'h7BDE, 16'h1234, 1, 1'b1);
      check_frame("bp-second", 16'h7BDE, 16'h5555, 0, 1'b1);
      $display("backpressure 1234 then 5555 checked (errors so far %0d)", n_err);
      prev_dig = 16'h7BDE;
      prev_hex = 16'h5555;

      // Reset mid-frame with a word pending: pending must be dropped.
      for (int i = 0; i < 3; i++) begin
         step();
         chk_disp("pre-reset", prev_dig, prev_hex);
      end
      load(16'hABCD, 4'b0000);
      step();
      step();
      rst_n = 1'b0;
      #1;
      chk("midrst dig_sel",     {12'h0, dig_sel},     16'h000E);
      chk("midrst hex",         {12'h0, hex},         16'h0001);
      chk("midrst in_ready",    {15'h0, in_ready},    16'h1);
      chk("midrst frame_start", {15'h0, frame_start}, 16'h0);
      @(posedge clk);
      #1;
      chk("midrst held dig_sel", {12'h0, dig_sel}, 16'h000E);
      rst_n = 1'b1;
      pos   = 0;
      check_frame("post-reset", 16'h7BDE, 16'h8421, 0, 1'b0);
      check_frame("post-reset2", 16'h7BDE, 16'h8421, 0, 1'b1);
      $display("mid-frame reset with pending ABCD checked (errors so far %0d)", n_err);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
